// File: rtl/shot_launcher.sv
// Ballistic shot launcher: latches the final charge on leaving CHARGE and steps the projectile once per TICK_LEN cycles.
// Latency: first step TICK_LEN cycles after launch; no backpressure, state/power are ignored until the shot resolves.
module shot_launcher #(
    parameter int TICK_LEN = 64,
    parameter int GRAVITY  = 1,
    parameter int X_MAX    = 639,
    parameter int TARGET_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [7:0] power,
    input  logic [9:0] target_x,
    output logic [9:0] x_pos,
    output logic [10:0] y_pos,
    output logic       flying,
    output logic       done,
    output logic       hit,
    output logic [7:0] shot_power
);
    localparam logic [3:0] CHARGE = 4'b0010;
    localparam int TW = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, FLY, DONE} fsm_t;

    fsm_t               fsm;
    logic [TW-1:0]      tick;
    logic [11:0]        x;
    logic signed [11:0] y;
    logic [4:0]         vx;
    logic signed [7:0]  vy;
    logic [9:0]         tgt;

    logic [11:0]        x_new;
    logic signed [11:0] y_new;
    logic               in_target;
    logic               step;

    always_comb begin
        x_new     = x + {7'd0, vx};
        y_new     = y + {{4{vy[7]}}, vy};
        in_target = ({2'b00, tgt} <= x_new) && (x_new < ({2'b00, tgt} + 12'(TARGET_W)));
        step      = (tick == TW'(TICK_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            tick       <= '0;
            x          <= '0;
            y          <= '0;
            vx         <= '0;
            vy         <= '0;
            tgt        <= '0;
            x_pos      <= '0;
            y_pos      <= '0;
            flying     <= 1'b0;
            done       <= 1'b0;
            hit        <= 1'b0;
            shot_power <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (state == CHARGE) fsm <= ARMED;
                end
                ARMED: begin
                    // power is only valid on this exit cycle; the counter clears it one cycle later
                    if (state != CHARGE) begin
                        shot_power <= power;
                        tgt        <= target_x;
                        vx         <= power[7:3];
                        vy         <= $signed({2'b00, power[7:2]});
                        x          <= '0;
                        y          <= '0;
                        tick       <= '0;
                        hit        <= 1'b0;
                        x_pos      <= '0;
                        y_pos      <= '0;
                        if (power == 8'd0) begin
                            fsm  <= DONE;
                            done <= 1'b1;
                        end else begin
                            fsm    <= FLY;
                            flying <= 1'b1;
                        end
                    end
                end
                FLY: begin
                    if (step) begin
                        tick <= '0;
                        if (x_new > 12'(X_MAX)) begin
                            x_pos  <= 10'(X_MAX);
                            y_pos  <= (y_new > 12'sd0) ? y_new[10:0] : 11'd0;
                            hit    <= 1'b0;
                            fsm    <= DONE;
                            done   <= 1'b1;
                            flying <= 1'b0;
                        end else if (y_new <= 12'sd0) begin
                            x_pos  <= x_new[9:0];
                            y_pos  <= '0;
                            hit    <= in_target;
                            fsm    <= DONE;
                            done   <= 1'b1;
                            flying <= 1'b0;
                        end else begin
                            x     <= x_new;
                            y     <= y_new;
                            vy    <= vy - 8'(GRAVITY);
                            x_pos <= x_new[9:0];
                            y_pos <= y_new[10:0];
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shot_launcher.sv
// Randomised scoreboard bench for shot_launcher against a step-by-step ballistic reference model.
module tb_shot_launcher;
    localparam int TICK  = 64;
    localparam int GRAV  = 1;
    localparam int XMAX  = 639;
    localparam int TGT_W = 16;
    localparam logic [3:0] CHARGE = 4'b0010;
    localparam logic [3:0] PLAY   = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [7:0]  power;
    logic [9:0]  target_x;
    logic [9:0]  x_pos;
    logic [10:0] y_pos;
    logic        flying;
    logic        done;
    logic        hit;
    logic [7:0]  shot_power;

    always #5 clk = ~clk;

    shot_launcher #(.TICK_LEN(TICK), .GRAVITY(GRAV), .X_MAX(XMAX), .TARGET_W(TGT_W)) dut (
        .clk(clk), .rst(rst), .state(state), .power(power), .target_x(target_x),
        .x_pos(x_pos), .y_pos(y_pos), .flying(flying), .done(done), .hit(hit),
        .shot_power(shot_power)
    );

    typedef struct {
        int steps;
        int x;
        int y;
        int hit;
        int pw;
        int launch;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int p, input int tx);
        exp_t e;
        int vx, vy, x, y;
        e.pw = p; e.steps = 0; e.x = 0; e.y = 0; e.hit = 0; e.launch = 0;
        vx = p / 8;
        vy = p / 4;
        x = 0;
        y = 0;
        if (p == 0) return e;
        for (int k = 1; k < 1000; k++) begin
            x += vx;
            y += vy;
            vy -= GRAV;
            if (x > XMAX) begin
                e.steps = k; e.x = XMAX; e.y = (y > 0) ? y : 0;
                return e;
            end
            if (y <= 0) begin
                e.steps = k; e.x = x; e.y = 0;
                e.hit = (x >= tx && x < tx + TGT_W) ? 1 : 0;
                return e;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // The push happens on the cycle the DUT samples state != CHARGE; the next edge is the launch edge.
    task automatic push_shot(input int p, input int tx);
        exp_t e;
        e = model(p, tx);
        e.launch = cyc + 1;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no shot outstanding, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_latency", cyc - e.launch, e.steps * TICK);
                chk("x_pos", int'(x_pos), e.x);
                chk("y_pos", int'(y_pos), e.y);
                chk("hit", int'(hit), e.hit);
                chk("shot_power", int'(shot_power), e.pw);
                chk("flying_at_done", int'(flying), 0);
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_timeout_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic shoot(input int p, input int tx, input bit toggle);
        exp_t m;
        m = model(p, tx);
        @(negedge clk);
        state = CHARGE;
        power = 8'($urandom);
        repeat (3) begin
            @(negedge clk);
            power = 8'($urandom);
        end
        @(negedge clk);
        state    = PLAY;
        power    = 8'(p);
        target_x = 10'(tx);
        push_shot(p, tx);
        @(negedge clk);
        power    = 8'd0;
        target_x = 10'($urandom);
        chk("flying_after_launch", int'(flying), (p != 0) ? 1 : 0);
        if (toggle && p != 0) begin
            repeat (10) @(negedge clk);
            state = CHARGE;
            power = 8'($urandom);
            repeat (5) @(negedge clk);
            state = PLAY;
            power = 8'd0;
        end
        wait_done(4000);
        @(negedge clk);
        chk("hit_hold", int'(hit), m.hit);
        chk("flying_idle", int'(flying), 0);
    endtask

    initial begin
        exp_t m;
        int p, tx;
        rst = 1'b1;
        state = 4'b0000;
        power = 8'd0;
        target_x = 10'd0;
        repeat (3) @(negedge clk);
        chk("rst_x_pos", int'(x_pos), 0);
        chk("rst_y_pos", int'(y_pos), 0);
        chk("rst_flying", int'(flying), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_shot_power", int'(shot_power), 0);
        rst = 1'b0;

        shoot(8'h40, 260, 1'b0);
        shoot(8'h40, 300, 1'b0);
        shoot(8'hFF, 100, 1'b0);
        shoot(8'h03, 0, 1'b0);
        shoot(8'h00, 5, 1'b0);
        shoot(8'h40, 260, 1'b1);

        // CHARGE held from just after launch through DONE: no re-arm in flight, re-arm afterwards
        @(negedge clk);
        state = CHARGE;
        power = 8'h11;
        repeat (3) @(negedge clk);
        state = PLAY;
        power = 8'h03;
        target_x = 10'd0;
        push_shot(8'h03, 0);
        @(negedge clk);
        state = CHARGE;
        power = 8'h20;
        wait_done(200);
        repeat (3) @(negedge clk);
        state = PLAY;
        power = 8'h40;
        target_x = 10'd260;
        push_shot(8'h40, 260);
        @(negedge clk);
        power = 8'd0;
        chk("rearm_flying", int'(flying), 1);
        wait_done(4000);

        // Reset mid-flight aborts the shot silently
        @(negedge clk);
        state = CHARGE;
        repeat (3) @(negedge clk);
        state = PLAY;
        power = 8'h40;
        target_x = 10'd260;
        push_shot(8'h40, 260);
        @(negedge clk);
        power = 8'd0;
        repeat (200) @(negedge clk);
        chk("midflight_flying", int'(flying), 1);
        chk("midflight_x_pos", int'(x_pos), 24);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_flying", int'(flying), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x_pos", int'(x_pos), 0);
        chk("abort_y_pos", int'(y_pos), 0);
        chk("abort_shot_power", int'(shot_power), 0);
        rst = 1'b0;
        repeat (2300) @(negedge clk);
        chk("abort_quiet_x_pos", int'(x_pos), 0);
        chk("abort_quiet_flying", int'(flying), 0);

        for (int i = 0; i < 12; i++) begin
            p = int'($urandom_range(0, 255));
            m = model(p, 0);
            tx = (m.x >= 20) ? m.x - int'($urandom_range(0, 20)) : int'($urandom_range(0, 20));
            shoot(p, tx, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
